// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single fixed-latency memory.
// Optional ARB_ROUND_ROBIN_EN macro replaces fixed data priority with alternating grants on ties.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    // instruction fetch (read-only)
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    // load/store
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    // shared memory
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e     state;
    logic [3:0] cnt;
    logic       sel_d;    // winner of the transfer in flight is the load/store port
    logic       grant_d;  // winner if a grant were made this cycle

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    always_comb begin
        grant_d = d_req && (!f_req || !last_d);
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            sel_d     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_done    <= 1'b0;
            d_done    <= 1'b0;
            f_rdata   <= '0;
            d_rdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    mem_we <= 1'b0;
                    if (f_req || d_req) begin
                        sel_d     <= grant_d;
                        mem_addr  <= grant_d ? d_addr : f_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        mem_we    <= grant_d && d_we;
                        cnt       <= 4'(MEM_LATENCY);
                        state     <= StAccess;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d    <= grant_d;
`endif
                    end
                end
                StAccess: begin
                    // write strobe lives only in the first access cycle
                    mem_we <= 1'b0;
                    cnt    <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state  <= StDone;
                        f_done <= !sel_d;
                        d_done <= sel_d;
                    end
                end
                StDone: begin
                    f_done <= 1'b0;
                    d_done <= 1'b0;
                    if (sel_d) begin
                        d_rdata <= mem_rdata;
                    end else begin
                        f_rdata <= mem_rdata;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at latency 1, one at latency 3, shared stimulus.
// Honours ARB_ROUND_ROBIN_EN for the tie-breaking expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_we;
    logic [63:0] f_addr, d_addr, d_wdata, mem_rdata;

    logic        a_f_done, a_d_done, a_mem_we;
    logic [63:0] a_f_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
    logic        b_f_done, b_d_done, b_mem_we;
    logic [63:0] b_f_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(1), .ADDR_W(64), .DATA_W(64)) u_dut_l1 (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_done    (a_f_done),
        .f_rdata   (a_f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (a_d_done),
        .d_rdata   (a_d_rdata),
        .mem_addr  (a_mem_addr),
        .mem_wdata (a_mem_wdata),
        .mem_we    (a_mem_we),
        .mem_rdata (mem_rdata)
    );

    mem_arbiter #(.MEM_LATENCY(3), .ADDR_W(64), .DATA_W(64)) u_dut_l3 (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_done    (b_f_done),
        .f_rdata   (b_f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (b_d_done),
        .d_rdata   (b_d_rdata),
        .mem_addr  (b_mem_addr),
        .mem_wdata (b_mem_wdata),
        .mem_we    (b_mem_we),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        f_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int first_done, n_pulse, n_both, n_f, n_g, t1, t2;
        logic we_seen;
        logic [3:0] grants;
        logic [3:0] exp_grants;

        f_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        do_reset();

        // reset state
        check("rst_f_done", 64'(a_f_done), 64'd0);
        check("rst_d_done", 64'(a_d_done), 64'd0);
        check("rst_mem_we", 64'(a_mem_we), 64'd0);
        check("rst_mem_addr", a_mem_addr, 64'd0);
        check("rst_mem_wdata", a_mem_wdata, 64'd0);
        check("rst_f_rdata", a_f_rdata, 64'd0);
        check("rst_d_rdata", a_d_rdata, 64'd0);

        // latency-1 fetch read
        mem_rdata = 64'h0000_0000_00A0_0093;
        f_addr    = 64'h10;
        f_req     = 1'b1;
        step();
        check("fetch_c1_addr", a_mem_addr, 64'h10);
        check("fetch_c1_we", 64'(a_mem_we), 64'd0);
        check("fetch_c1_done", 64'(a_f_done), 64'd0);
        step();
        check("fetch_c2_fdone", 64'(a_f_done), 64'd1);
        check("fetch_c2_ddone", 64'(a_d_done), 64'd0);
        check("fetch_c2_we", 64'(a_mem_we), 64'd0);
        f_req = 1'b0;
        step();
        check("fetch_c3_fdone", 64'(a_f_done), 64'd0);
        check("fetch_rdata", a_f_rdata, 64'h00A0_0093);
        check("fetch_d_rdata", a_d_rdata, 64'd0);

        // latency-1 write
        do_reset();
        d_addr  = 64'h20;
        d_wdata = 64'hDEAD_BEEF;
        d_we    = 1'b1;
        d_req   = 1'b1;
        step();
        check("wr_c1_we", 64'(a_mem_we), 64'd1);
        check("wr_c1_addr", a_mem_addr, 64'h20);
        check("wr_c1_wdata", a_mem_wdata, 64'hDEAD_BEEF);
        check("wr_c1_done", 64'(a_d_done), 64'd0);
        step();
        check("wr_c2_we", 64'(a_mem_we), 64'd0);
        check("wr_c2_ddone", 64'(a_d_done), 64'd1);
        check("wr_c2_fdone", 64'(a_f_done), 64'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        check("wr_c3_ddone", 64'(a_d_done), 64'd0);
        check("wr_c3_we", 64'(a_mem_we), 64'd0);

        // reset in the first access cycle of a write
        do_reset();
        d_we  = 1'b1;
        d_req = 1'b1;
        step();
        check("abort_c1_we", 64'(a_mem_we), 64'd1);
        reset = 1'b1;
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        reset = 1'b0;
        check("abort_we", 64'(a_mem_we), 64'd0);
        check("abort_addr", a_mem_addr, 64'd0);
        check("abort_wdata", a_mem_wdata, 64'd0);
        n_pulse = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_d_done || a_f_done) n_pulse++;
            step();
        end
        check("abort_no_done", 64'(n_pulse), 64'd0);

        // both requesters held high: tie resolution
        do_reset();
        f_addr  = 64'h10;
        d_addr  = 64'h20;
        f_req   = 1'b1;
        d_req   = 1'b1;
        grants  = '0;
        n_g     = 0;
        n_f     = 0;
        n_both  = 0;
        for (int i = 0; i < 13; i++) begin
            step();
            if (a_f_done && a_d_done) n_both++;
            if (a_f_done) n_f++;
            if ((a_f_done || a_d_done) && n_g < 4) begin
                grants[n_g] = a_d_done;
                n_g++;
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_grants = 4'b0101;
        check("tie_f_count", 64'(n_f), 64'd2);
`else
        exp_grants = 4'b1111;
        check("tie_f_count", 64'(n_f), 64'd0);
`endif
        check("tie_n_grants", 64'(n_g), 64'd4);
        check("tie_order", 64'(grants), 64'(exp_grants));
        check("tie_never_both", 64'(n_both), 64'd0);

        // back-to-back fetch held through done
        do_reset();
        f_req = 1'b1;
        t1 = 0;
        t2 = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (a_f_done) begin
                if (t1 == 0) t1 = i;
                else if (t2 == 0) t2 = i;
            end
        end
        f_req = 1'b0;
        check("b2b_first", 64'(t1), 64'd2);
        check("b2b_spacing", 64'(t2 - t1), 64'd3);

        // latency-3 data read
        do_reset();
        mem_rdata  = 64'hCAFE_0000_1234_5678;
        d_addr     = 64'h8;
        d_we       = 1'b0;
        d_req      = 1'b1;
        first_done = 0;
        n_pulse    = 0;
        we_seen    = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (b_mem_we) we_seen = 1'b1;
            if (i == 1) check("l3_addr", b_mem_addr, 64'h8);
            if (b_d_done) begin
                n_pulse++;
                if (first_done == 0) first_done = i;
                d_req = 1'b0;
            end
        end
        check("l3_done_cycle", 64'(first_done), 64'd4);
        check("l3_done_pulses", 64'(n_pulse), 64'd1);
        check("l3_no_we", 64'(we_seen), 64'd0);
        check("l3_d_rdata", b_d_rdata, 64'hCAFE_0000_1234_5678);
        check("l3_f_rdata", b_f_rdata, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
